// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl
// Interrupt controller sitting between the interrupt sources and the core's
// trap logic. Rising edges on the source lines set pending bits; pending bits
// are masked by a software enable register and one winner is chosen by fixed
// priority (index 0 highest). A single request is presented to the core and
// a claim/complete handshake keeps exactly one interrupt in service.
//
// Ports
//   clk          system clock, rising-edge
//   rst          asynchronous active-high reset
//   src          level interrupt lines, a 0->1 transition raises pending
//   cfg_we       enable-register write strobe
//   cfg_wdata    new enable mask
//   enable       current enable mask
//   pending      current pending bits
//   irq          request to core (derived from registers only)
//   claim        core accepts the current request (1-cycle pulse)
//   claim_id     id of the interrupt in service (held until next claim)
//   busy         an interrupt is in service
//   complete     core finished its handler (1-cycle pulse)
//   complete_id  id being completed
//   claim_count  total accepted claims, wraps modulo 2^32
// ---------------------------------------------------------------------------
module intr_ctrl #(
    parameter int unsigned NSRC = 4,
    parameter int unsigned IDW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSRC-1:0]   src,
    input  logic              cfg_we,
    input  logic [NSRC-1:0]   cfg_wdata,
    output logic [NSRC-1:0]   enable,
    output logic [NSRC-1:0]   pending,
    output logic              irq,
    input  logic              claim,
    output logic [IDW-1:0]    claim_id,
    output logic              busy,
    input  logic              complete,
    input  logic [IDW-1:0]    complete_id,
    output logic [31:0]       claim_count
);

    localparam int unsigned CNTW = 32;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SERVE = 1'b1;

    logic              r_state;
    logic [NSRC-1:0]   r_enable;
    logic [NSRC-1:0]   r_pending;
    logic [NSRC-1:0]   r_src_q;
    logic [IDW-1:0]    r_claim_id;
    logic [CNTW-1:0]   r_claim_count;

    logic              w_state_nxt;
    logic              w_take;
    logic              w_release;
    logic [NSRC-1:0]   w_rise;
    logic [NSRC-1:0]   w_eligible;
    logic              w_any;
    logic [IDW-1:0]    w_winner;
    logic [NSRC-1:0]   w_clr;
    logic [NSRC-1:0]   w_pending_nxt;
    logic [NSRC-1:0]   w_enable_nxt;
    logic [IDW-1:0]    w_claim_id_nxt;
    logic [CNTW-1:0]   w_claim_count_nxt;

    // Edge detect and eligibility
    assign w_rise     = src & ~r_src_q;
    assign w_eligible = r_pending & r_enable;
    assign w_any      = |w_eligible;

    // Fixed-priority pick: scanning downward leaves the lowest set index
    always_comb begin
        w_winner = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = IDW'(i);
            end
        end
    end

    // Next-state logic and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A claim without a live request is dropped; complete is ignored
                if (claim && w_any) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (complete && (complete_id == r_claim_id)) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath next values; a same-cycle rising edge re-sets a claimed bit
    always_comb begin
        w_clr             = w_take ? (NSRC'(1) << w_winner) : '0;
        w_pending_nxt     = (r_pending & ~w_clr) | w_rise;
        w_enable_nxt      = cfg_we ? cfg_wdata : r_enable;
        w_claim_id_nxt    = w_take ? w_winner : r_claim_id;
        w_claim_count_nxt = w_take ? (r_claim_count + CNTW'(1)) : r_claim_count;
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_enable      <= '0;
            r_pending     <= '0;
            r_src_q       <= '0;
            r_claim_id    <= '0;
            r_claim_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_enable      <= w_enable_nxt;
            r_pending     <= w_pending_nxt;
            r_src_q       <= src;
            r_claim_id    <= w_claim_id_nxt;
            r_claim_count <= w_claim_count_nxt;
        end
    end

    // w_release only documents the SERVE->IDLE transition for readers/probes
    logic w_unused;
    assign w_unused = w_release;

    assign enable      = r_enable;
    assign pending     = r_pending;
    assign claim_id    = r_claim_id;
    assign claim_count = r_claim_count;
    assign busy        = (r_state == ST_SERVE);
    assign irq         = (r_state == ST_IDLE) && w_any;

endmodule

// File: tb/tb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_ctrl
// Self-checking bench for intr_ctrl: directed vector table, hand sequence for
// reset during service, then randomized traffic against a reference model.
// ---------------------------------------------------------------------------
module tb_intr_ctrl;

    localparam int unsigned NSRC = 4;
    localparam int unsigned IDW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NSRC-1:0]   src;
    logic              cfg_we;
    logic [NSRC-1:0]   cfg_wdata;
    logic [NSRC-1:0]   enable;
    logic [NSRC-1:0]   pending;
    logic              irq;
    logic              claim;
    logic [IDW-1:0]    claim_id;
    logic              busy;
    logic              complete;
    logic [IDW-1:0]    complete_id;
    logic [31:0]       claim_count;

    intr_ctrl #(.NSRC(NSRC), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .src         (src),
        .cfg_we      (cfg_we),
        .cfg_wdata   (cfg_wdata),
        .enable      (enable),
        .pending     (pending),
        .irq         (irq),
        .claim       (claim),
        .claim_id    (claim_id),
        .busy        (busy),
        .complete    (complete),
        .complete_id (complete_id),
        .claim_count (claim_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: interrupt bookkeeping as sets of pending ids
    logic [NSRC-1:0]   m_en;
    logic [NSRC-1:0]   m_pend;
    logic [NSRC-1:0]   m_prev_src;
    logic [IDW-1:0]    m_cid;
    logic              m_busy;
    logic [31:0]       m_cnt;

    function automatic int first_set(input logic [NSRC-1:0] v);
        for (int i = 0; i < int'(NSRC); i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic model_irq();
        return !m_busy && (first_set(m_pend & m_en) >= 0);
    endfunction

    task automatic model_reset();
        m_en = '0; m_pend = '0; m_prev_src = '0;
        m_cid = '0; m_busy = 1'b0; m_cnt = 32'd0;
    endtask

    task automatic model_step();
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        w = first_set(m_pend & m_en);
        if (!m_busy) begin
            if (claim && w >= 0) begin
                m_cid    = IDW'(w);
                m_pend[w] = 1'b0;
                m_cnt    = m_cnt + 32'd1;
                m_busy   = 1'b1;
            end
        end else if (complete && complete_id == m_cid) begin
            m_busy = 1'b0;
        end
        for (int i = 0; i < int'(NSRC); i++) begin
            if (src[i] && !m_prev_src[i]) m_pend[i] = 1'b1;
        end
        if (cfg_we) m_en = cfg_wdata;
        m_prev_src = src;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".enable"},      32'(enable),      32'(m_en));
        chk({tag, ".pending"},     32'(pending),     32'(m_pend));
        chk({tag, ".irq"},         32'(irq),         32'(model_irq()));
        chk({tag, ".busy"},        32'(busy),        32'(m_busy));
        chk({tag, ".claim_id"},    32'(claim_id),    32'(m_cid));
        chk({tag, ".claim_count"}, claim_count,      m_cnt);
    endtask

    task automatic idle_inputs();
        cfg_we = 1'b0; cfg_wdata = '0; claim = 1'b0;
        complete = 1'b0; complete_id = '0;
    endtask

    typedef struct {
        logic [3:0]  src;
        logic        we;
        logic [3:0]  wdata;
        logic        claim;
        logic        cmp;
        logic [3:0]  cmp_id;
        logic [3:0]  e_en;
        logic [3:0]  e_pend;
        logic        e_irq;
        logic        e_busy;
        logic [3:0]  e_cid;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vec [NVEC];

    initial begin
        string nm;

        // src, we, wdata, claim, cmp, cmp_id | en, pend, irq, busy, cid, cnt
        vec[0]  = '{4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 32'd0};
        vec[1]  = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF, 4'h4, 1'b1, 1'b0, 4'h0, 32'd0};
        vec[2]  = '{4'h4, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b1, 4'h2, 32'd1};
        vec[3]  = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b1, 4'h1, 4'hF, 4'h0, 1'b0, 1'b1, 4'h2, 32'd1};
        vec[4]  = '{4'h4, 1'b0, 4'h0, 1'b0, 1'b1, 4'h2, 4'hF, 4'h0, 1'b0, 1'b0, 4'h2, 32'd1};
        vec[5]  = '{4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF, 4'hA, 1'b1, 1'b0, 4'h2, 32'd1};
        vec[6]  = '{4'hA, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'hF, 4'h8, 1'b0, 1'b1, 4'h1, 32'd2};
        vec[7]  = '{4'hA, 1'b0, 4'h0, 1'b0, 1'b1, 4'h1, 4'hF, 4'h8, 1'b1, 1'b0, 4'h1, 32'd2};
        vec[8]  = '{4'hA, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b1, 4'h3, 32'd3};
        vec[9]  = '{4'hA, 1'b0, 4'h0, 1'b0, 1'b1, 4'h3, 4'hF, 4'h0, 1'b0, 1'b0, 4'h3, 32'd3};
        vec[10] = '{4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 4'h3, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, 32'd3};
        vec[11] = '{4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0, 4'h3, 32'd3};
        vec[12] = '{4'h1, 1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0, 4'h3, 32'd3};
        vec[13] = '{4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b1, 4'h0, 32'd4};
        vec[14] = '{4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 32'd4};
        vec[15] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 32'd4};
        vec[16] = '{4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0, 4'h0, 32'd4};
        vec[17] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0, 4'h0, 32'd4};
        vec[18] = '{4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 1'b0, 1'b1, 4'h0, 32'd5};
        vec[19] = '{4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h1, 4'h1, 1'b1, 1'b0, 4'h0, 32'd5};

        rst = 1'b1; src = '0; idle_inputs();
        model_reset();
        tick(); tick();
        chk("reset.enable",      32'(enable),   32'd0);
        chk("reset.pending",     32'(pending),  32'd0);
        chk("reset.irq",         32'(irq),      32'd0);
        chk("reset.busy",        32'(busy),     32'd0);
        chk("reset.claim_id",    32'(claim_id), 32'd0);
        chk("reset.claim_count", claim_count,   32'd0);
        rst = 1'b0;
        repeat (8) tick();

        // Directed table
        for (int v = 0; v < NVEC; v++) begin
            src = vec[v].src; cfg_we = vec[v].we; cfg_wdata = vec[v].wdata;
            claim = vec[v].claim; complete = vec[v].cmp; complete_id = vec[v].cmp_id;
            tick();
            nm = $sformatf("vec%0d", v);
            chk({nm, ".enable"},      32'(enable),   32'(vec[v].e_en));
            chk({nm, ".pending"},     32'(pending),  32'(vec[v].e_pend));
            chk({nm, ".irq"},         32'(irq),      32'(vec[v].e_irq));
            chk({nm, ".busy"},        32'(busy),     32'(vec[v].e_busy));
            chk({nm, ".claim_id"},    32'(claim_id), 32'(vec[v].e_cid));
            chk({nm, ".claim_count"}, claim_count,   vec[v].e_cnt);
        end
        idle_inputs();

        // Reset while in service with pending = 1010, src[3] held through release
        cfg_we = 1'b1; cfg_wdata = 4'hF; src = 4'h1;
        tick(); idle_inputs();
        src = 4'hB;
        tick();
        chk("rstseq.pending_pre", 32'(pending), 32'hB);
        claim = 1'b1;
        tick(); idle_inputs();
        check_model("rstseq.serve");
        chk("rstseq.busy_pre",    32'(busy),    32'd1);
        chk("rstseq.pending_mid", 32'(pending), 32'hA);
        src = 4'h8;
        #2;
        rst = 1'b1;
        #1;
        chk("rstseq.async.enable",      32'(enable),   32'd0);
        chk("rstseq.async.pending",     32'(pending),  32'd0);
        chk("rstseq.async.irq",         32'(irq),      32'd0);
        chk("rstseq.async.busy",        32'(busy),     32'd0);
        chk("rstseq.async.claim_id",    32'(claim_id), 32'd0);
        chk("rstseq.async.claim_count", claim_count,   32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rstseq.after.pending", 32'(pending), 32'h8);
        chk("rstseq.after.irq",     32'(irq),     32'd0);
        check_model("rstseq.after");

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < int'(NSRC); i++) begin
                if ($urandom_range(0, 7) == 0) src[i] = ~src[i];
            end
            cfg_we    = ($urandom_range(0, 19) == 0);
            cfg_wdata = NSRC'($urandom);
            claim     = ($urandom_range(0, 2) == 0);
            complete  = ($urandom_range(0, 2) == 0);
            complete_id = ($urandom_range(0, 3) == 0) ? IDW'($urandom) : m_cid;
            rst       = ($urandom_range(0, 499) == 0);
            tick();
            check_model($sformatf("rand%0d", c));
        end
        rst = 1'b0; idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
- Interrupt controller between external/timer interrupt sources and the core's trap logic.
- Edge-detects up to NSRC sources into pending bits, masks them with a software-written enable register, and picks one winner by fixed priority.
- Presents one request to the core and runs a claim/complete handshake, so only one interrupt is in service at a time.
- Replaces the core's raw ext_intr/timer_intr wiring.

Parameters:
- NSRC, 4, number of interrupt sources (2..16).
- IDW, 4, width of interrupt id; must satisfy 2^IDW >= NSRC.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- src  input  NSRC  level interrupt lines; source i raises on 0->1 transition.
- cfg_we  input  1  write strobe for the enable register.
- cfg_wdata  input  NSRC  new enable mask.
- enable  output  NSRC  current enable mask.
- pending  output  NSRC  current pending bits.
- irq  output  1  request to core.
- claim  input  1  core accepts the current request (1-cycle pulse).
- claim_id  output  IDW  id of the interrupt in service.
- busy  output  1  an interrupt is in service (state SERVE).
- complete  input  1  core finished its handler (1-cycle pulse).
- complete_id  input  IDW  id being completed.
- claim_count  output  32  total accepted claims.

Behaviour:
- Reset values (asynchronous, all registers):
  - enable = 0, pending = 0, src_q = 0, claim_id = 0, busy = 0, claim_count = 0, state = IDLE.
  - Because src_q resets to 0, a source held high across reset release sets its pending bit at the first clock edge.
- Edge detect:
  - src_q[i] registers src[i] every cycle.
  - pending[i] is set at the edge where src[i] = 1 and src_q[i] = 0.
  - Pending is set independently of enable.
- Pending clear: only by a successful claim of id i. If a new rising edge on source i coincides with its claim, set wins and pending[i] stays 1.
- Enable:
  - cfg_we writes cfg_wdata into enable at the clock edge; the new mask takes effect in the next cycle.
  - Pending bits masked off remain pending and raise irq once enabled.
- Arbitration: eligible = pending & enable. Winner is the lowest set index (index 0 has highest priority).
- irq = (state == IDLE) && (eligible != 0). Combinational from registers; no input-to-output path.
  - Latency from a src rising edge to irq: irq is high in the cycle after the edge that sets pending.
- State machine, two states:
  - IDLE:
    - Claim with irq = 1: claim_id <= winner, pending[winner] cleared (subject to the set-wins rule), claim_count += 1 (wraps modulo 2^32), state -> SERVE.
    - Claim with irq = 0: ignored, no state change.
    - Complete: ignored.
  - SERVE:
    - busy = 1 and irq = 0. Claim is ignored; new edges still set pending.
    - Complete with complete_id == claim_id: state -> IDLE. irq may re-assert in the following cycle if eligible is nonzero.
    - Complete with a mismatched id: ignored, stays SERVE.
- claim_id holds its value after return to IDLE until the next claim.
- Simultaneous claim and complete in IDLE: the claim is processed, the complete is ignored.
- Reset asserted mid-SERVE: everything returns immediately to reset values. The in-flight interrupt and all pending bits are lost.

Test Plan:
- Reset, write enable = 4'b1111, raise src[2] at cycle 10 → pending = 4'b0100 and irq = 1 one cycle later. Claim → claim_id = 2, busy = 1, pending = 0, claim_count = 1.
- src[1] and src[3] rise in the same cycle with all sources enabled → claim_id = 1. After complete(1), irq re-asserts next cycle; second claim → claim_id = 3, claim_count = 2.
- enable = 4'b0000, raise src[0] → pending[0] = 1, irq stays 0. Write enable = 4'b0001 → irq = 1 the cycle after the write.
- In SERVE with claim_id = 2, pulse complete with complete_id = 1 → busy stays 1. Then complete_id = 2 → busy = 0.
- Hold src[0] high and claim → pending[0] clears and is not re-set while src stays high. Drop and re-raise src[0] in the claim cycle → pending[0] = 1 after the claim.
- Assert rst while busy = 1 with pending = 4'b1010 → all outputs 0 immediately. src[3] held high through reset release → pending[3] = 1 after the first edge.
